// File: rtl/div_pkg.sv
// Shared types and elaboration helpers for the divider arbiter slice.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 16;

  // Index width for n entries; never below 1 so single-bit indices stay legal.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic bit nreq_ok(input int n);
    return (n >= NREQ_MIN) && (n <= NREQ_MAX);
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Request/response bundle between NREQ requesters and the divider arbiter.
interface div_arbiter_if #(
  parameter int BITS = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BITS-1:0] req_n;
  logic [NREQ*BITS-1:0] req_d;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [BITS-1:0]      resp_q;
  logic [BITS-1:0]      resp_r;
  logic                 resp_dz;
  logic                 resp_ovf;
  logic                 busy;

  modport master (
    output req_valid, req_n, req_d, resp_ready,
    input  req_ready, resp_valid, resp_q, resp_r, resp_dz, resp_ovf, busy
  );

  modport slave (
    input  req_valid, req_n, req_d, resp_ready,
    output req_ready, resp_valid, resp_q, resp_r, resp_dz, resp_ovf, busy
  );
endinterface

// File: rtl/div.sv
// Sequential signed restoring divider; no reset, a start pulse reloads everything.
module div #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            i_start,
  input  logic [BITS-1:0] i_n,
  input  logic [BITS-1:0] i_d,
  output logic            o_rdy,
  output logic [BITS-1:0] o_q,
  output logic [BITS-1:0] o_r
);
  localparam int CW = div_pkg::clog2(BITS);

  logic [BITS-1:0] r_rem, r_quo, r_dabs;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q, r_neg_r, r_rdy;

  logic [BITS-1:0] w_n_abs, w_d_abs, w_rem_cur, w_quo_cur, w_dabs_cur, w_rem_nxt;
  logic [BITS:0]   w_trial, w_diff;
  logic            w_take;

  assign w_n_abs = i_n[BITS-1] ? -i_n : i_n;
  assign w_d_abs = i_d[BITS-1] ? -i_d : i_d;

  // The first iteration runs on the start edge itself, so only BITS-1 follow.
  assign w_rem_cur  = i_start ? '0      : r_rem;
  assign w_quo_cur  = i_start ? w_n_abs : r_quo;
  assign w_dabs_cur = i_start ? w_d_abs : r_dabs;

  assign w_trial   = {w_rem_cur, w_quo_cur[BITS-1]};
  assign w_diff    = w_trial - {1'b0, w_dabs_cur};
  assign w_take    = (w_trial >= {1'b0, w_dabs_cur});
  assign w_rem_nxt = w_take ? w_diff[BITS-1:0] : w_trial[BITS-1:0];

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_rem   <= w_rem_nxt;
      r_quo   <= {w_quo_cur[BITS-2:0], w_take};
      r_dabs  <= w_d_abs;
      r_neg_q <= i_n[BITS-1] ^ i_d[BITS-1];
      r_neg_r <= i_n[BITS-1];
      r_cnt   <= CW'(BITS - 1);
      r_rdy   <= 1'b0;
    end else if (r_cnt != '0) begin
      r_rem <= w_rem_nxt;
      r_quo <= {w_quo_cur[BITS-2:0], w_take};
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_rdy <= 1'b1;
    end
  end

  assign o_rdy = r_rdy;
  assign o_q   = r_neg_q ? -r_quo : r_quo;
  assign o_r   = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/div_rr_pick.sv
// Combinational round-robin picker: first request after i_ptr, wrapping modulo NREQ.
module div_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int w_j;
      w_j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_idx        = PW'(w_j);
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sharing of one sequential signed divider among NREQ requesters.
// state | meaning
// IDLE  | nothing in flight; grant the round-robin winner
// START | one-cycle start pulse into the div core
// WAIT  | core iterating; capture q/r when rdy rises
// RESP  | result held for the owner until it accepts
module div_arbiter
  import div_pkg::*;
#(
  parameter int BITS = 32,
  parameter int NREQ = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  div_arbiter_if.slave  bus
);
  localparam int PW = clog2(NREQ);
  localparam logic [BITS-1:0] MOST_NEG = {1'b1, {(BITS-1){1'b0}}};

  if (!nreq_ok(NREQ)) begin : g_nreq_bad
    $error("div_arbiter: NREQ must be within 2..16");
  end

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, r_owner;
  logic [BITS-1:0] r_n, r_d, r_q, r_r;
  logic            r_dz, r_ovf;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic            w_any, w_accept, w_capture, w_div_start, w_div_rdy;
  logic [BITS-1:0] w_sel_n, w_sel_d, w_div_q, w_div_r;

  div_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  div #(.BITS(BITS)) u_div (
    .clk     (clk),
    .i_start (w_div_start),
    .i_n     (r_n),
    .i_d     (r_d),
    .o_rdy   (w_div_rdy),
    .o_q     (w_div_q),
    .o_r     (w_div_r)
  );

  assign w_sel_n = bus.req_n[int'(w_idx)*BITS +: BITS];
  assign w_sel_d = bus.req_d[int'(w_idx)*BITS +: BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = '0;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_div_start   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          bus.req_ready = w_grant;
          w_accept      = 1'b1;
          w_state_nxt   = (w_sel_d == '0) ? RESP : START;
        end
      end
      START: begin
        w_div_start = 1'b1;
        w_state_nxt = WAIT;
      end
      // rdy is already low here: the core clears it on the start edge.
      WAIT: begin
        if (w_div_rdy) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready[r_owner]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= PW'(NREQ - 1);
      r_owner <= '0;
      r_n     <= '0;
      r_d     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_owner <= w_idx;
      r_ptr   <= w_idx;
      r_n     <= w_sel_n;
      r_d     <= w_sel_d;
      if (w_sel_d == '0) begin
        r_q   <= '0;
        r_r   <= w_sel_n;
        r_dz  <= 1'b1;
        r_ovf <= 1'b0;
      end else begin
        r_dz  <= 1'b0;
        r_ovf <= (w_sel_n == MOST_NEG) && (&w_sel_d);
      end
    end else if (w_capture) begin
      r_q <= w_div_q;
      r_r <= w_div_r;
    end
  end

  assign bus.resp_valid = (r_state == RESP) ? (NREQ'(1) << r_owner) : '0;
  assign bus.resp_q     = r_q;
  assign bus.resp_r     = r_r;
  assign bus.resp_dz    = r_dz;
  assign bus.resp_ovf   = r_ovf;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed cases plus randomized traffic vs a cycle-level reference.
module tb_div_arbiter;
  localparam int BITS = 8;
  localparam int NREQ = 3;
  localparam int LAT  = BITS + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_arbiter_if #(.BITS(BITS), .NREQ(NREQ)) bus ();
  div_arbiter #(.BITS(BITS), .NREQ(NREQ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [NREQ-1:0]           tb_valid  = '0;
  logic [NREQ-1:0]           tb_rready = '0;
  logic [NREQ-1:0][BITS-1:0] tb_n      = '0;
  logic [NREQ-1:0][BITS-1:0] tb_d      = '0;

  assign bus.req_valid  = tb_valid;
  assign bus.req_n      = tb_n;
  assign bus.req_d      = tb_d;
  assign bus.resp_ready = tb_rready;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit              m_busy  = 1'b0;
  int              m_cnt   = 0;
  int              m_ptr   = NREQ - 1;
  int              m_owner = 0;
  logic [BITS-1:0] m_q, m_r;
  bit              m_dz, m_ovf;
  bit              tb_hold = 1'b0;
  int              acc_cyc = 0;
  bit              acc_now, hs_now;
  int              acc_idx;
  logic [NREQ-1:0] obs_rv, obs_rr;
  logic [BITS-1:0] obs_q, obs_r;
  logic            obs_dz, obs_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic ref_div(input logic [BITS-1:0] n, input logic [BITS-1:0] d,
                         output logic [BITS-1:0] q, output logic [BITS-1:0] r,
                         output bit dz, output bit ovf);
    int sn, sd;
    sn = $signed(n);
    sd = $signed(d);
    dz = 1'b0;
    ovf = 1'b0;
    if (d == '0) begin
      q = '0; r = n; dz = 1'b1;
    end else if (n == 8'h80 && d == 8'hFF) begin
      q = 8'h80; r = '0; ovf = 1'b1;
    end else begin
      q = BITS'(sn / sd);
      r = BITS'(sn % sd);
    end
  endtask

  function automatic logic [BITS-1:0] rand_op();
    case ($urandom % 6)
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      default: return BITS'($urandom);
    endcase
  endfunction

  // Called at a falling edge with inputs already driven; checks, predicts the next edge, advances.
  task automatic step();
    logic [NREQ-1:0] exp_rr, exp_rv;
    int w;
    #1;
    acc_cyc++;
    if (m_busy && m_cnt > 0) m_cnt--;
    w = pick(m_ptr, tb_valid);
    exp_rr  = (!m_busy && w >= 0) ? (NREQ'(1) << w) : '0;
    exp_rv  = (m_busy && m_cnt == 0) ? (NREQ'(1) << m_owner) : '0;
    obs_rr  = bus.req_ready;
    obs_rv  = bus.resp_valid;
    obs_q   = bus.resp_q;
    obs_r   = bus.resp_r;
    obs_dz  = bus.resp_dz;
    obs_ovf = bus.resp_ovf;
    check("req_ready", obs_rr, exp_rr);
    check("req_ready_onehot", ($countones(obs_rr) <= 1), 1);
    check("resp_valid", obs_rv, exp_rv);
    check("busy", bus.busy, m_busy);
    check("div_start", dut.w_div_start, (m_busy && !m_dz && m_cnt == LAT - 1));
    if (exp_rv != '0) begin
      check("resp_q", obs_q, m_q);
      check("resp_r", obs_r, m_r);
      check("resp_dz", obs_dz, m_dz);
      check("resp_ovf", obs_ovf, m_ovf);
    end
    acc_now = 1'b0;
    hs_now  = 1'b0;
    if (!m_busy && w >= 0) begin
      m_busy = 1'b1; m_owner = w; m_ptr = w;
      ref_div(tb_n[w], tb_d[w], m_q, m_r, m_dz, m_ovf);
      m_cnt = m_dz ? 1 : LAT;
      acc_now = 1'b1; acc_idx = w; acc_cyc = 0;
    end else if (m_busy && m_cnt == 0 && tb_rready[m_owner]) begin
      m_busy = 1'b0;
      hs_now = 1'b1;
    end
    @(negedge clk);
    if (acc_now && !tb_hold) tb_valid[acc_idx] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_q", bus.resp_q, 0);
    check("rst_resp_r", bus.resp_r, 0);
    check("rst_resp_dz", bus.resp_dz, 0);
    check("rst_resp_ovf", bus.resp_ovf, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_div_start", dut.w_div_start, 0);
    m_busy = 1'b0; m_cnt = 0; m_ptr = NREQ - 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input string tag, input int idx, input logic [BITS-1:0] n, input logic [BITS-1:0] d,
                        input logic [BITS-1:0] eq, input logic [BITS-1:0] er,
                        input bit edz, input bit eovf, input int elat);
    bit got;
    got = 1'b0;
    tb_rready = NREQ'(1) << idx;
    tb_n[idx] = n;
    tb_d[idx] = d;
    tb_valid[idx] = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (obs_rv != '0) got = 1'b1;
    end
    check({tag, "_done"}, got, 1);
    check({tag, "_lat"}, acc_cyc, elat);
    check({tag, "_owner"}, obs_rv, NREQ'(1) << idx);
    check({tag, "_q"}, obs_q, eq);
    check({tag, "_r"}, obs_r, er);
    check({tag, "_dz"}, obs_dz, edz);
    check({tag, "_ovf"}, obs_ovf, eovf);
    tb_rready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord[$];
    int exp_ord[5] = '{0, 1, 2, 0, 1};
    int hs_at;
    bit seen;

    do_reset();

    run_op("t1", 0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, LAT);
    run_op("t2a", 1, 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0, LAT);
    run_op("t2b", 1, 8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, LAT);
    run_op("t3", 2, 8'd5, 8'd0, 8'd0, 8'd5, 1'b1, 1'b0, 1);
    run_op("t4", 0, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, LAT);

    // response back-pressure, then reset during an in-flight computation
    tb_rready = '0;
    tb_n[0] = 8'd100; tb_d[0] = 8'd7; tb_valid[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (obs_rv != '0) seen = 1'b1;
    end
    check("t6_resp_seen", seen, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t6_hold_valid", obs_rv, 3'b001);
      check("t6_hold_q", obs_q, 8'd14);
      check("t6_hold_r", obs_r, 8'd2);
    end
    tb_rready[0] = 1'b1;
    step();
    tb_rready = '0;
    tb_n[1] = 8'd50; tb_d[1] = 8'd3; tb_valid[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (acc_now) seen = 1'b1;
    end
    check("t6_accept", seen, 1);
    for (int k = 0; k < 3; k++) step();
    do_reset();
    run_op("t6b", 0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, LAT);

    // all requesters saturating: round-robin order and one bubble per handshake
    do_reset();
    tb_hold = 1'b1;
    tb_n[0] = 8'd30;  tb_d[0] = 8'd4;
    tb_n[1] = 8'hC4;  tb_d[1] = 8'd7;
    tb_n[2] = 8'd90;  tb_d[2] = 8'hFB;
    tb_rready = '1;
    tb_valid  = '1;
    hs_at = -100;
    for (int k = 0; k < 200 && ord.size() < 5; k++) begin
      step();
      if (hs_now) hs_at = k;
      if (acc_now) begin
        if (ord.size() > 0) check("t5_bubble", k - hs_at, 1);
        ord.push_back(acc_idx);
      end
    end
    check("t5_count", ord.size(), 5);
    for (int i = 0; i < ord.size(); i++) check("t5_order", ord[i], exp_ord[i]);
    tb_hold  = 1'b0;
    tb_valid = '0;
    for (int k = 0; k < 20; k++) step();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!tb_valid[i]) begin
          if (!(m_busy && m_owner == i) && ($urandom % 3 == 0)) begin
            tb_n[i] = rand_op();
            tb_d[i] = rand_op();
            tb_valid[i] = 1'b1;
          end
        end else if ($urandom % 10 == 0) begin
          tb_valid[i] = 1'b0;
        end
      end
      tb_rready = NREQ'($urandom);
      step();
    end
    tb_valid  = '0;
    tb_rready = '1;
    for (int k = 0; k < 20; k++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
